// File: rtl/rom_copy_engine.sv
// Boot-time copy engine: streams a block from a fixed-latency source ROM into
// main RAM one byte at a time, then pulses done/exec_en with the entry address.
module rom_copy_engine #(
  parameter int SRC_AW     = 16,
  parameter int DST_AW     = 21,
  parameter int DW         = 8,
  parameter int ROM_LAT    = 1,
  parameter bit AUTO_START = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [SRC_AW-1:0] src_base,
  input  logic [DST_AW-1:0] dst_base,
  input  logic [SRC_AW:0]   length,
  input  logic [15:0]       exec_addr_in,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [DW-1:0]     src_data,
  output logic [DST_AW-1:0] dst_addr,
  output logic [DW-1:0]     dst_data,
  output logic              dst_wr,
  input  logic              dst_wait,
  output logic              busy,
  output logic              done,
  output logic              exec_en,
  output logic [15:0]       exec_addr,
  output logic [1:0]        state_dbg
);

  // Handshake: a write transfers on a rising edge where dst_wr=1 and
  // dst_wait=0; dst_wr, dst_addr and dst_data stay stable until then.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(ROM_LAT - 1);

  state_t          state, state_nxt;
  logic            auto_pend;
  logic [2:0]      lat_cnt;
  logic [SRC_AW:0] remain;
  logic            go, capture, accept;

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Held high through reset so the first free cycle acts as a start request.
  always_ff @(posedge clk_sys) begin
    if (reset) auto_pend <= AUTO_START;
    else       auto_pend <= 1'b0;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if ((start || auto_pend) && !abort) begin
          go        = 1'b1;
          state_nxt = (length == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (lat_cnt == LAT_LAST) begin
          capture   = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        // A transfer in the abort cycle still counts; abort only ends the copy.
        accept = !dst_wait;
        if (abort)       state_nxt = IDLE;
        else if (accept) state_nxt = (remain == (SRC_AW+1)'(1)) ? FINISH : FETCH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      src_addr  <= '0;
      dst_addr  <= '0;
      dst_data  <= '0;
      remain    <= '0;
      exec_addr <= '0;
      lat_cnt   <= '0;
    end else begin
      if (go) begin
        src_addr  <= src_base;
        dst_addr  <= dst_base;
        remain    <= length;
        exec_addr <= exec_addr_in;
      end
      if (state == FETCH && !capture && !abort) lat_cnt <= lat_cnt + 3'd1;
      else                                      lat_cnt <= '0;
      if (capture) dst_data <= src_data;
      if (accept) begin
        src_addr <= src_addr + SRC_AW'(1);
        dst_addr <= dst_addr + DST_AW'(1);
        remain   <= remain - (SRC_AW+1)'(1);
      end
    end
  end

  assign dst_wr    = (state == WRITE);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH) && !abort;
  assign exec_en   = done;
  assign state_dbg = state;

endmodule

// File: tb/tb_rom_copy_engine.sv
// Bench for rom_copy_engine: instance a (ROM_LAT=1, auto start) and
// instance b (ROM_LAT=3, manual start) checked against an expected-write queue.
module tb_rom_copy_engine;
  localparam int W = 21 + 8;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic        start_a, abort_a, dst_wait_a, dst_wr_a, busy_a, done_a, exec_en_a;
  logic [15:0] src_base_a, exec_in_a, src_addr_a, exec_addr_a;
  logic [20:0] dst_base_a, dst_addr_a;
  logic [16:0] length_a;
  logic [7:0]  src_data_a, dst_data_a;
  logic [1:0]  state_a;

  logic        start_b, abort_b, dst_wait_b, dst_wr_b, busy_b, done_b, exec_en_b;
  logic [15:0] src_base_b, exec_in_b, src_addr_b, exec_addr_b;
  logic [20:0] dst_base_b, dst_addr_b;
  logic [16:0] length_b;
  logic [7:0]  src_data_b, dst_data_b, rom_p1_b, rom_p2_b;
  logic [1:0]  state_b;

  int checks = 0, errors = 0;
  int writes_a = 0, done_cnt_a = 0, cyc_a = 0, last_acc_a = -1;
  int writes_b = 0, done_cnt_b = 0, cyc_b = 0, last_acc_b = -1, stall_cnt_b = 0;
  logic stall_prev_a = 1'b0, acc_prev_a = 1'b0, stall_prev_b = 1'b0, acc_prev_b = 1'b0;
  logic [W-1:0] hold_a, hold_b;
  logic [15:0] exec_seen_a = '0, exec_seen_b = '0;
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];

  rom_copy_engine #(.SRC_AW(16), .DST_AW(21), .DW(8), .ROM_LAT(1), .AUTO_START(1'b1)) dut_a (
    .clk_sys(clk_sys), .reset(reset), .start(start_a), .abort(abort_a),
    .src_base(src_base_a), .dst_base(dst_base_a), .length(length_a), .exec_addr_in(exec_in_a),
    .src_addr(src_addr_a), .src_data(src_data_a), .dst_addr(dst_addr_a), .dst_data(dst_data_a),
    .dst_wr(dst_wr_a), .dst_wait(dst_wait_a), .busy(busy_a), .done(done_a), .exec_en(exec_en_a),
    .exec_addr(exec_addr_a), .state_dbg(state_a));

  rom_copy_engine #(.SRC_AW(16), .DST_AW(21), .DW(8), .ROM_LAT(3), .AUTO_START(1'b0)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .start(start_b), .abort(abort_b),
    .src_base(src_base_b), .dst_base(dst_base_b), .length(length_b), .exec_addr_in(exec_in_b),
    .src_addr(src_addr_b), .src_data(src_data_b), .dst_addr(dst_addr_b), .dst_data(dst_data_b),
    .dst_wr(dst_wr_b), .dst_wait(dst_wait_b), .busy(busy_b), .done(done_b), .exec_en(exec_en_b),
    .exec_addr(exec_addr_b), .state_dbg(state_b));

  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h5a;
  endfunction

  // ROM a answers in the same cycle; ROM b has two register stages (valid in 3rd cycle).
  assign src_data_a = rom_f(src_addr_a);
  always @(posedge clk_sys) begin
    rom_p1_b <= rom_f(src_addr_b);
    rom_p2_b <= rom_p1_b;
  end
  assign src_data_b = rom_p2_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input bit sel, input logic [15:0] s, input logic [20:0] d, input int n);
    logic [W-1:0] e;
    for (int i = 0; i < n; i++) begin
      e = {d + 21'(i), rom_f(s + 16'(i))};
      if (sel) exp_b_q.push_back(e);
      else     exp_a_q.push_back(e);
    end
  endtask

  task automatic wait_done(input bit sel, input int budget, input bit rnd);
    int d0, n;
    d0 = sel ? done_cnt_b : done_cnt_a;
    n  = 0;
    while ((sel ? done_cnt_b : done_cnt_a) == d0 && n < budget) begin
      step();
      if (rnd) dst_wait_a = ($urandom_range(0, 3) == 0);
      n++;
    end
    if (rnd) dst_wait_a = 1'b0;
    check("done_wait", 32'((sel ? done_cnt_b : done_cnt_a) != d0), 1);
  endtask

  always @(negedge clk_sys) begin : mon_a
    logic [W-1:0] e;
    cyc_a++;
    if (stall_prev_a && !reset)
      check("stall_hold_a", 32'({dst_wr_a, dst_addr_a, dst_data_a}), 32'({1'b1, hold_a}));
    if (acc_prev_a) check("wr_drop_a", 32'(dst_wr_a), 0);
    acc_prev_a = dst_wr_a && !dst_wait_a;
    if (acc_prev_a) begin
      writes_a++;
      if (last_acc_a >= 0) check("gap_a", 32'(cyc_a - last_acc_a >= 2), 1);
      last_acc_a = cyc_a;
      check("q_avail_a", 32'(exp_a_q.size() != 0), 1);
      if (exp_a_q.size() != 0) begin
        e = exp_a_q.pop_front();
        check("wr_a", 32'({dst_addr_a, dst_data_a}), 32'(e));
      end
    end
    stall_prev_a = dst_wr_a && dst_wait_a;
    hold_a = {dst_addr_a, dst_data_a};
    if (done_a || exec_en_a) begin
      check("exec_en_a", 32'(exec_en_a), 32'(done_a));
      if (done_a) begin done_cnt_a++; exec_seen_a = exec_addr_a; end
    end
  end

  always @(negedge clk_sys) begin : mon_b
    logic [W-1:0] e;
    cyc_b++;
    if (stall_prev_b && !reset)
      check("stall_hold_b", 32'({dst_wr_b, dst_addr_b, dst_data_b}), 32'({1'b1, hold_b}));
    if (acc_prev_b) check("wr_drop_b", 32'(dst_wr_b), 0);
    acc_prev_b = dst_wr_b && !dst_wait_b;
    if (acc_prev_b) begin
      writes_b++;
      if (last_acc_b >= 0) check("gap_b", 32'(cyc_b - last_acc_b >= 4), 1);
      last_acc_b = cyc_b;
      check("q_avail_b", 32'(exp_b_q.size() != 0), 1);
      if (exp_b_q.size() != 0) begin
        e = exp_b_q.pop_front();
        check("wr_b", 32'({dst_addr_b, dst_data_b}), 32'(e));
      end
    end
    stall_prev_b = dst_wr_b && dst_wait_b;
    if (stall_prev_b) stall_cnt_b++;
    hold_b = {dst_addr_b, dst_data_b};
    if (done_b || exec_en_b) begin
      check("exec_en_b", 32'(exec_en_b), 32'(done_b));
      if (done_b) begin done_cnt_b++; exec_seen_b = exec_addr_b; end
    end
  end

  initial begin
    int w0, d0, nb, n;
    start_a = 0; abort_a = 0; dst_wait_a = 0;
    src_base_a = 16'h0000; dst_base_a = 21'h0; length_a = 17'd276; exec_in_a = 16'h1234;
    start_b = 0; abort_b = 0; dst_wait_b = 0;
    src_base_b = 16'h0; dst_base_b = 21'h0; length_b = 17'd0; exec_in_b = 16'h0;

    // Reset values
    repeat (3) step();
    check("rst_busy", 32'(busy_a), 0);
    check("rst_wr", 32'(dst_wr_a), 0);
    check("rst_src", 32'(src_addr_a), 0);
    check("rst_dst", 32'(dst_addr_a), 0);
    check("rst_data", 32'(dst_data_a), 0);
    check("rst_done", 32'({done_a, exec_en_a}), 0);
    check("rst_exec", 32'(exec_addr_a), 0);
    check("rst_state", 32'(state_a), 0);

    // Auto-start copy of 276 bytes
    push(0, 16'h0000, 21'h0, 276);
    w0 = writes_a;
    reset = 1'b0;
    wait_done(0, 2000, 0);
    check("auto_writes", 32'(writes_a - w0), 276);
    check("auto_q", 32'(exp_a_q.size()), 0);
    check("auto_done", 32'(done_cnt_a), 1);
    check("auto_exec", 32'(exec_seen_a), 32'h1234);
    repeat (2) step();
    check("idle_after_done", 32'(busy_a), 0);
    check("exec_hold", 32'(exec_addr_a), 32'h1234);
    check("b_no_auto", 32'({busy_b, 31'(writes_b)}), 0);

    // Zero length: one busy cycle, a done pulse, no writes
    length_a = 17'd0; exec_in_a = 16'hBEEF; d0 = done_cnt_a; w0 = writes_a; nb = 0;
    start_a = 1; step(); start_a = 0;
    for (int i = 0; i < 5; i++) begin nb += int'(busy_a); step(); end
    check("len0_busy", 32'(nb), 1);
    check("len0_done", 32'(done_cnt_a - d0), 1);
    check("len0_writes", 32'(writes_a - w0), 0);
    check("len0_exec", 32'(exec_seen_a), 32'hBEEF);

    // Pointer wrap at the top of both address spaces
    src_base_a = 16'hFFFE; dst_base_a = 21'h1FFFFE; length_a = 17'd4; exec_in_a = 16'h0F00;
    push(0, 16'hFFFE, 21'h1FFFFE, 4);
    w0 = writes_a;
    start_a = 1; step(); start_a = 0;
    wait_done(0, 200, 0);
    check("wrap_writes", 32'(writes_a - w0), 4);
    check("wrap_q", 32'(exp_a_q.size()), 0);

    // Random backpressure, with a start pulse mid-copy that must be ignored
    src_base_a = 16'h1000; dst_base_a = 21'h5000; length_a = 17'd20; exec_in_a = 16'h2222;
    push(0, 16'h1000, 21'h5000, 20);
    w0 = writes_a;
    start_a = 1; step(); start_a = 0;
    repeat (3) step();
    src_base_a = 16'h7777; dst_base_a = 21'h7777; length_a = 17'd5; exec_in_a = 16'h3333;
    start_a = 1; step(); start_a = 0;
    wait_done(0, 1000, 1);
    check("bp_writes", 32'(writes_a - w0), 20);
    check("bp_q", 32'(exp_a_q.size()), 0);
    check("bp_exec", 32'(exec_seen_a), 32'h2222);

    // Start and abort together in IDLE: nothing starts
    nb = 0;
    start_a = 1; abort_a = 1; step(); start_a = 0; abort_a = 0;
    for (int i = 0; i < 5; i++) begin nb += int'(busy_a); step(); end
    check("start_abort_idle", 32'(nb), 0);

    // Abort after the 10th accepted write of 100
    src_base_a = 16'h2000; dst_base_a = 21'h3000; length_a = 17'd100; exec_in_a = 16'h4444;
    push(0, 16'h2000, 21'h3000, 10);
    w0 = writes_a; d0 = done_cnt_a; n = 0;
    start_a = 1; step(); start_a = 0;
    while (writes_a - w0 < 10 && n < 2000) begin step(); n++; end
    abort_a = 1; step(); abort_a = 0;
    check("abort_busy", 32'(busy_a), 0);
    check("abort_wr", 32'(dst_wr_a), 0);
    repeat (10) step();
    check("abort_writes", 32'(writes_a - w0), 10);
    check("abort_no_done", 32'(done_cnt_a - d0), 0);
    check("abort_q", 32'(exp_a_q.size()), 0);

    // Instance b: ROM_LAT=3, dst_wait held for 5 cycles on the 2nd write
    src_base_b = 16'h0100; dst_base_b = 21'h0200; length_b = 17'd4; exec_in_b = 16'h5555;
    push(1, 16'h0100, 21'h0200, 4);
    start_b = 1; step(); start_b = 0;
    n = 0;
    while (writes_b == 0 && n < 100) begin step(); n++; end
    dst_wait_b = 1; n = 0;
    while (stall_cnt_b < 5 && n < 100) begin step(); n++; end
    dst_wait_b = 0;
    wait_done(1, 200, 0);
    check("lat3_writes", 32'(writes_b), 4);
    check("lat3_q", 32'(exp_b_q.size()), 0);
    check("lat3_done", 32'(done_cnt_b), 1);
    check("lat3_exec", 32'(exec_seen_b), 32'h5555);

    // Reset while a write is pending, then auto-restart of the full copy
    src_base_a = 16'h4000; dst_base_a = 21'h4000; length_a = 17'd50; exec_in_a = 16'h6666;
    push(0, 16'h4000, 21'h4000, 50);
    d0 = done_cnt_a;
    start_a = 1; step(); start_a = 0;
    repeat (10) step();
    dst_wait_a = 1; n = 0;
    while (!dst_wr_a && n < 100) begin step(); n++; end
    reset = 1; step();
    check("rst_mid_wr", 32'(dst_wr_a), 0);
    check("rst_mid_busy", 32'(busy_a), 0);
    check("rst_mid_no_done", 32'(done_cnt_a - d0), 0);
    exp_a_q.delete();
    src_base_a = 16'h0000; dst_base_a = 21'h0; length_a = 17'd276; exec_in_a = 16'h1234;
    dst_wait_a = 0;
    push(0, 16'h0000, 21'h0, 276);
    w0 = writes_a; d0 = done_cnt_a;
    step();
    reset = 0;
    wait_done(0, 2000, 0);
    check("restart_writes", 32'(writes_a - w0), 276);
    check("restart_q", 32'(exp_a_q.size()), 0);
    check("restart_done", 32'(done_cnt_a - d0), 1);
    check("restart_exec", 32'(exec_seen_a), 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
